avalon_reg_bank: RTL
====================

// Module: avalon_reg_bank
// PURPOSE
//  Parametrised Avalon-MM slave register bank; generalises the fixed ID/loopback slave.
//  Provides NUM_RW host-writable control registers driven out to fabric logic.
//  Provides NUM_RO read-only status registers sampled from fabric inputs.
//  Supports byte-enables, per-register write strobes and an unmapped-access error counter.
//  Sits between the Avalon interconnect (driven by the host bridge) and user cores.
// PARAMETERS
//  DATA_W       32            data width; must be a multiple of 8
//  ADDR_W       16            Avalon address width
//  INDEX_SHIFT  8             register index = avalon_slave_address >> INDEX_SHIFT
//  NUM_RW       8             number of RW registers (indices 0..NUM_RW-1), 1..64
//  NUM_RO       4             number of RO registers (indices NUM_RW..NUM_RW+NUM_RO-1), 0..64
//  RW_RESET     0             reset value loaded into every RW register
//  UNMAPPED_VAL 32'hDEADBEEF  readdata returned for indices >= NUM_RW+NUM_RO
// PORTS
//  clock                     in   1              single system clock, rising edge
//  reset_n                   in   1              asynchronous reset, active low
//  avalon_slave_address      in   ADDR_W         word address
//  avalon_slave_write        in   1              write request
//  avalon_slave_writedata    in   DATA_W         write data
//  avalon_slave_byteenable   in   DATA_W/8       byte lane enables for writes
//  avalon_slave_read         in   1              read request
//  avalon_slave_readdata     out  DATA_W         read data; valid when read=1 and waitrequest=0
//  avalon_slave_waitrequest  out  1              stall
//  rw_regs_out               out  NUM_RW*DATA_W  RW register contents; reg i at [i*DATA_W +: DATA_W]
//  ro_regs_in                in   NUM_RO*DATA_W  status inputs; RO reg j at [j*DATA_W +: DATA_W]
//  wr_strobe                 out  NUM_RW         1-cycle pulse on the cycle after reg i is updated
//  err_count                 out  16             saturating count of unmapped reads and writes
// BEHAVIOUR
//  Reset values (reset_n low, async):
//   - readdata = 0; every RW register = RW_RESET; wr_strobe = 0; err_count = 0; FSM = IDLE.
//   - Reset asserted mid-read aborts the read: FSM returns to IDLE, no readdata is delivered.
//  Read FSM (states IDLE, RESP):
//   - waitrequest = read && (state==IDLE), combinational.
//   - IDLE + read: decode the index and register the result into readdata; go to RESP.
//   - RESP: waitrequest is low and the master samples readdata; go to IDLE unconditionally.
//   - Fixed 2-cycle read latency. A read held high is re-issued from IDLE (2 cycles per read).
//   - RO data is sampled from ro_regs_in on the IDLE cycle.
//   - readdata holds its last value outside RESP.
//  Read decode:
//   - idx < NUM_RW: RW register value.
//   - NUM_RW <= idx < NUM_RW+NUM_RO: ro_regs_in value.
//   - Otherwise: UNMAPPED_VAL, and err_count increments once per read, on the IDLE cycle.
//   - Index bits above the register range are compared in full; there is no aliasing or wrap.
//  Write:
//   - Zero wait states. Accepted on any cycle where write=1 && waitrequest=0.
//   - idx < NUM_RW: each byte lane k with byteenable[k]=1 is updated; other lanes hold.
//   - wr_strobe[idx] pulses on the next cycle if byteenable != 0.
//   - byteenable == 0: no update and no strobe.
//   - Write to an RO index: ignored silently; no strobe, no error.
//   - Write to an unmapped index: ignored; err_count increments.
//  Simultaneous read and write (protocol violation, defined anyway):
//   - The write is accepted only when waitrequest=0, i.e. during RESP or with read low.
//   - A read in RESP returns the pre-write value.
//  err_count saturates at 16'hFFFF and never wraps.
//   - A read and a write both unmapped in one cycle add 2, still saturating.
//  Address bits below INDEX_SHIFT are ignored.
// TESTING
//  1 Reset with RW_RESET=5 -> every rw_regs_out slice = 5, readdata = 0, waitrequest = 0 while idle.
//  2 Write 32'h12345678 to addr 16'h0300, be=4'hF; read it back
//    -> rw_regs_out reg3 = 32'h12345678; wr_strobe[3] pulses 1 cycle;
//    -> readback has waitrequest high 1 cycle, then data 32'h12345678.
//  3 Write 32'hAABBCCDD to addr 16'h0300, be=4'b0101 over 32'h12345678
//    -> reg3 = 32'h12BB56DD; be=4'h0 -> no change, no strobe.
//  4 ro_regs_in reg1 = 32'hCAFEF00D; read addr 16'h0900 (idx 9 = NUM_RW+1)
//    -> 32'hCAFEF00D; write to the same address -> ignored, err_count unchanged.
//  5 Read idx 12, then write idx 200 -> read returns 32'hDEADBEEF, err_count = 2;
//    force err_count to 16'hFFFE, make 3 unmapped accesses -> err_count = 16'hFFFF.
//  6 Drop reset_n while in RESP -> waitrequest = 0, FSM = IDLE, regs = RW_RESET;
//    after release, a new read completes normally in 2 cycles.

Source files
------------

// File: rtl/avalon_reg_bank.sv
// avalon_reg_bank: Avalon-MM slave with NUM_RW control registers, NUM_RO status registers and an unmapped-access error counter
//   clock/reset_n: system clock, async active-low reset
//   avalon_slave_*: word-addressed slave port; register index = address >> INDEX_SHIFT; reads take 2 cycles, writes take 0 wait states
//   rw_regs_out/wr_strobe: control register contents and per-register update pulses
//   ro_regs_in: status inputs returned on reads of the RO indices
//   err_count: saturating count of unmapped reads and writes
module avalon_reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int INDEX_SHIFT = 8,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 4,
  parameter logic [DATA_W-1:0] RW_RESET = '0,
  parameter logic [DATA_W-1:0] UNMAPPED_VAL = DATA_W'(32'hDEADBEEF),
  localparam int RO_W = (NUM_RO > 0 ? NUM_RO : 1) * DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        avalon_slave_address,
  input  logic                     avalon_slave_write,
  input  logic [DATA_W-1:0]        avalon_slave_writedata,
  input  logic [DATA_W/8-1:0]      avalon_slave_byteenable,
  input  logic                     avalon_slave_read,
  output logic [DATA_W-1:0]        avalon_slave_readdata,
  output logic                     avalon_slave_waitrequest,
  output logic [NUM_RW*DATA_W-1:0] rw_regs_out,
  input  logic [RO_W-1:0]          ro_regs_in,
  output logic [NUM_RW-1:0]        wr_strobe,
  output logic [15:0]              err_count
);
  localparam int NB = DATA_W / 8;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_next;
  logic [31:0] idx;
  logic [DATA_W-1:0] rw_q [NUM_RW];
  logic [DATA_W-1:0] rd_next;
  logic [NUM_RW-1:0] hit;
  logic wr_ok, rd_take, unmapped;
  logic [16:0] err_sum;
  // index is widened to 32 bits so every upper address bit takes part in the decode (no aliasing)
  assign idx = 32'(avalon_slave_address) >> INDEX_SHIFT;
  assign avalon_slave_waitrequest = avalon_slave_read && state == IDLE;
  assign rd_take = avalon_slave_read && state == IDLE;
  assign wr_ok = avalon_slave_write && !avalon_slave_waitrequest;
  assign unmapped = idx >= 32'(NUM_RW + NUM_RO);
  assign err_sum = {1'b0, err_count} + 17'(rd_take && unmapped) + 17'(wr_ok && unmapped);
  for (genvar r = 0; r < NUM_RW; r++) begin : g_rw
    assign hit[r] = wr_ok && idx == 32'(r) && |avalon_slave_byteenable;
    assign rw_regs_out[r*DATA_W +: DATA_W] = rw_q[r];
  end
  always_comb begin
    state_next = rd_take ? RESP : IDLE;
    rd_next = UNMAPPED_VAL;
    for (int i = 0; i < NUM_RW; i++)
      if (idx == 32'(i)) rd_next = rw_q[i];
    for (int j = 0; j < NUM_RO; j++)
      if (idx == 32'(NUM_RW + j)) rd_next = ro_regs_in[j*DATA_W +: DATA_W];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      avalon_slave_readdata <= '0;
      wr_strobe <= '0;
      err_count <= '0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= RW_RESET;
    end else begin
      state <= state_next;
      if (rd_take) avalon_slave_readdata <= rd_next;
      wr_strobe <= hit;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      for (int i = 0; i < NUM_RW; i++)
        for (int k = 0; k < NB; k++)
          if (hit[i] && avalon_slave_byteenable[k]) rw_q[i][k*8 +: 8] <= avalon_slave_writedata[k*8 +: 8];
    end
endmodule
